// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and width helper for the debounce bank.
package debounce_pkg;
  localparam int STABLE_TICKS_DEF = 4095;
  localparam int TICK_DIV_DEF = 1;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: synchroniser, stability counter, level and edge strobes for one input.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter logic INIT_BIT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic change
);
  localparam int CW = clog2_min1(STABLE_TICKS);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, diff;
  assign s = sync[SYNC_STAGES-1];
  assign diff = s ^ level;
  // change is the pre-register strobe so the bank can align any_change with rise/fall
  assign change = diff & tick & (cnt == CMAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= {SYNC_STAGES{INIT_BIT}};
      cnt   <= '0;
      level <= INIT_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], din};
      cnt   <= (!diff || change) ? '0 : cnt + CW'(tick);
      level <= change ? s : level;
      rise  <= change & s;
      fall  <= change & ~s;
    end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debouncers sharing one sample-tick prescaler.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int              N_CH         = 4,
  parameter int              STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int              TICK_DIV     = TICK_DIV_DEF,
  parameter int              SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter logic [N_CH-1:0] INIT_VAL     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] data_in,
  output logic [N_CH-1:0] data_debounced,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_change
);
  localparam int PW = clog2_min1(TICK_DIV);
  logic [PW-1:0] presc;
  logic [N_CH-1:0] change;
  logic tick;
  assign tick = (TICK_DIV == 1) || (presc == PW'(TICK_DIV - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc      <= '0;
      any_change <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + PW'(1);
      any_change <= |change;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES),
      .INIT_BIT    (INIT_VAL[i])
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .din   (data_in[i]),
      .level (data_debounced[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .change(change[i])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: history-window model of two bank configurations plus directed checks.
module tb_debounce_bank;
  localparam int HMAX = 1024;
  logic clk, rst_n, cmp_en;
  logic [3:0] da, db;
  logic [3:0] dbnc_a, rise_a, fall_a, dbnc_b, rise_b, fall_b;
  logic any_a, any_b;
  int checks = 0, failures = 0;

  debounce_bank #(.N_CH(4), .STABLE_TICKS(4), .TICK_DIV(1), .SYNC_STAGES(2), .INIT_VAL(4'b0000)) u_a (
    .clk(clk), .rst_n(rst_n), .data_in(da), .data_debounced(dbnc_a),
    .rise(rise_a), .fall(fall_a), .any_change(any_a));
  debounce_bank #(.N_CH(4), .STABLE_TICKS(3), .TICK_DIV(4), .SYNC_STAGES(2), .INIT_VAL(4'b0000)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(db), .data_debounced(dbnc_b),
    .rise(rise_b), .fall(fall_b), .any_change(any_b));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: input history per edge; an output flips on a tick once STABLE_TICKS ticks
  // have elapsed with the synchronised input continuously differing since the last flip.
  logic [3:0] dh [2][HMAX];
  logic [3:0] dm [2], rm [2], fm [2];
  logic am [2];
  int lu [2][4];
  int cyc;

  function automatic int st(input int b); return b ? 3 : 4; endfunction
  function automatic int td(input int b); return b ? 4 : 1; endfunction
  function automatic int is_tick(input int b, input int k); return (k % td(b)) == td(b) - 1 ? 1 : 0; endfunction
  function automatic logic s_at(input int b, input int k, input int c);
    return (k >= 2) ? dh[b][k-2][c] : 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int b = 0; b < 2; b++) begin
        dm[b] <= '0; rm[b] <= '0; fm[b] <= '0; am[b] <= 1'b0;
        for (int c = 0; c < 4; c++) lu[b][c] <= -1;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        logic [3:0] nd, nr, nf;
        nd = dm[b]; nr = '0; nf = '0;
        for (int c = 0; c < 4; c++) begin
          int n;
          n = 0;
          if (is_tick(b, cyc) == 1)
            for (int k = cyc; k > lu[b][c] && k >= 0 && s_at(b, k, c) != dm[b][c] && n < st(b); k--)
              n += is_tick(b, k);
          if (n == st(b)) begin
            nd[c] = ~dm[b][c]; nr[c] = ~dm[b][c]; nf[c] = dm[b][c];
            lu[b][c] <= cyc;
          end
        end
        dm[b] <= nd; rm[b] <= nr; fm[b] <= nf; am[b] <= |(nr | nf);
      end
      if (cyc < HMAX) begin
        dh[0][cyc] <= da;
        dh[1][cyc] <= db;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("a_deb", dbnc_a, dm[0]); chk("a_rise", rise_a, rm[0]);
    chk("a_fall", fall_a, fm[0]); chk("a_any", any_a, am[0]);
    chk("b_deb", dbnc_b, dm[1]); chk("b_rise", rise_b, rm[1]);
    chk("b_fall", fall_b, fm[1]); chk("b_any", any_b, am[1]);
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_a(input logic [3:0] v); @(negedge clk); da = v; endtask
  task automatic set_b(input logic [3:0] v); @(negedge clk); db = v; endtask

  initial begin
    int n;
    cmp_en = 0; rst_n = 0; da = 4'b1010; db = 4'b0000;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    chk("rst_deb", dbnc_a, 0);
    chk("rst_strobes", {rise_a, fall_a, any_a}, 0);
    rst_n = 1;
    wait_edges(5); chk("start_e4_deb", dbnc_a, 0);
    wait_edges(1);
    chk("start_deb", dbnc_a, 4'b1010); chk("start_rise", rise_a, 4'b1010);
    chk("start_any", any_a, 1); chk("start_fall", fall_a, 0);
    wait_edges(1); chk("start_rise_end", rise_a, 0); chk("start_any_end", any_a, 0);
    // three-cycle glitch on ch0
    set_a(4'b1011); repeat (3) @(negedge clk); da = 4'b1010;
    wait_edges(8); chk("glitch_deb", dbnc_a, 4'b1010); chk("glitch_strobes", {rise_a, fall_a}, 0);
    // clean fall on ch2
    set_a(4'b1110); wait_edges(8); chk("fall_setup", dbnc_a, 4'b1110);
    set_a(4'b1010); wait_edges(5); chk("fall_e4_deb", dbnc_a, 4'b1110);
    wait_edges(1);
    chk("fall_deb", dbnc_a, 4'b1010); chk("fall_strobe", fall_a, 4'b0100);
    chk("fall_rise0", rise_a, 0); chk("fall_any", any_a, 1);
    wait_edges(1); chk("fall_strobe_end", fall_a, 0);
    // independent channels, two edges apart
    set_a(4'b0000); wait_edges(8); chk("indep_setup", dbnc_a, 0);
    set_a(4'b0010); @(negedge clk); set_a(4'b1010);
    wait_edges(4); chk("indep_rise1", rise_a, 4'b0010); chk("indep_any1", any_a, 1);
    wait_edges(1); chk("indep_gap", {rise_a, any_a}, 0);
    wait_edges(1); chk("indep_rise3", rise_a, 4'b1000); chk("indep_any2", any_a, 1);
    wait_edges(1); chk("indep_end", {rise_a, any_a}, 0);
    // input toggling every cycle never settles
    for (int i = 0; i < 12; i++) begin @(negedge clk); da[0] = ~da[0]; end
    @(negedge clk); da[0] = 1'b0;
    wait_edges(6); chk("toggle_deb", dbnc_a, 4'b1010);
    // prescaled bank: step latency and 5-cycle glitch
    set_b(4'b0001);
    n = 0;
    do begin wait_edges(1); n++; end while (dbnc_b[0] == 1'b0 && n < 20);
    chk("presc_latency_in_window", (n >= 11 && n <= 17), 1);
    chk("presc_rise", rise_b, 4'b0001);
    set_b(4'b0011); repeat (5) @(negedge clk); db = 4'b0001;
    wait_edges(20); chk("presc_glitch_deb", dbnc_b, 4'b0001);
    // reset two cycles into a count
    set_a(4'b1011); @(negedge clk); @(negedge clk);
    #2 rst_n = 0; #1;
    chk("midrst_deb", dbnc_a, 0); chk("midrst_strobes", {rise_a, fall_a, any_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_edges(5); chk("midrst_e4_deb", dbnc_a, 0);
    wait_edges(1); chk("midrst_deb_after", dbnc_a, 4'b1011); chk("midrst_rise", rise_a, 4'b1011);
    wait_edges(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
